decode_ctrl: RTL

DECODE_CTRL -- requirements
Module: decode_ctrl

---
 rtl/decode_ctrl.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/decode_ctrl.sv
// Instruction decode controller: captures one instruction word, decodes it for the ALU,
// sequences data-memory handshakes and branches, and keeps the registered {Z,V,N} flags.
module decode_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [3:0]  alu_op,
    output logic [3:0]  rd_sel,
    output logic [3:0]  rs_sel,
    output logic [3:0]  rt_sel,
    output logic [15:0] imm,
    output logic        use_imm,
    output logic        dec_valid,
    output logic        reg_we,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_ack,
    input  logic        alu_z,
    input  logic        alu_v,
    input  logic        alu_n,
    output logic [2:0]  flags,
    output logic        branch_taken,
    output logic        halted
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MEM  = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam logic [3:0] OP_LW  = 4'h8;
    localparam logic [3:0] OP_SW  = 4'h9;
    localparam logic [3:0] OP_LLB = 4'hA;
    localparam logic [3:0] OP_LHB = 4'hB;
    localparam logic [3:0] OP_B   = 4'hC;
    localparam logic [3:0] OP_BR  = 4'hD;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t      state_q;
    logic [15:0] instr_q;
    logic [2:0]  flags_q;
    logic [2:0]  flags_d;
    logic        instr_ready_q;
    logic        dec_valid_q;
    logic        reg_we_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic        branch_taken_q;
    logic        halted_q;
    logic [15:0] imm_s;
    logic        use_imm_s;
    logic [3:0]  rs_sel_s;
    logic        lw_done_s;

    // Opcodes that write the register file from EXEC (LW writes later, on its memory ack).
    function automatic logic writes_reg(input logic [3:0] op);
        logic we;
        case (op)
            4'h0, 4'h1, 4'h2, 4'h3,
            4'h4, 4'h5, 4'h6, 4'h7,
            OP_LLB, OP_LHB, 4'hE: we = 1'b1;
            default:              we = 1'b0;
        endcase
        return we;
    endfunction

    // Branch condition against flags packed as {Z,V,N}.
    function automatic logic cond_met(input logic [2:0] cond, input logic [2:0] f);
        logic hit;
        case (cond)
            3'b000:  hit = ~f[2];
            3'b001:  hit = f[2];
            3'b010:  hit = ~f[2] & ~f[0];
            3'b011:  hit = f[0];
            3'b100:  hit = f[2] | ~f[0];
            3'b101:  hit = f[0] | f[2];
            3'b110:  hit = f[1];
            3'b111:  hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Operand decode from the captured word, never from the live input bus.
    always_comb begin
        imm_s     = 16'h0000;
        use_imm_s = 1'b0;
        rs_sel_s  = instr_q[7:4];
        case (instr_q[15:12])
            4'h4, 4'h5, 4'h6: begin
                use_imm_s = 1'b1;
                imm_s     = {12'h000, instr_q[3:0]};
            end
            OP_LW, OP_SW: begin
                use_imm_s = 1'b1;
                imm_s     = {{11{instr_q[3]}}, instr_q[3:0], 1'b0};
            end
            OP_LLB, OP_LHB: begin
                use_imm_s = 1'b1;
                imm_s     = {8'h00, instr_q[7:0]};
                rs_sel_s  = instr_q[11:8];
            end
            OP_B: begin
                use_imm_s = 1'b0;
                imm_s     = {{6{instr_q[8]}}, instr_q[8:0], 1'b0};
            end
            default: begin
                use_imm_s = 1'b0;
                imm_s     = 16'h0000;
            end
        endcase
    end

    // Flag values loaded at the end of EXEC.
    always_comb begin
        flags_d = flags_q;
        case (instr_q[15:12])
            4'h0, 4'h1:             flags_d = {alu_z, alu_v, alu_n};
            4'h2, 4'h4, 4'h5, 4'h6: flags_d = {alu_z, flags_q[1:0]};
            default:                flags_d = flags_q;
        endcase
    end

    // Control FSM with registered handshake and enable outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            instr_q        <= 16'h0000;
            flags_q        <= 3'b000;
            instr_ready_q  <= 1'b1;
            dec_valid_q    <= 1'b0;
            reg_we_q       <= 1'b0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            branch_taken_q <= 1'b0;
            halted_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (instr_valid) begin
                        instr_q        <= instr;
                        state_q        <= EXEC;
                        instr_ready_q  <= 1'b0;
                        dec_valid_q    <= 1'b1;
                        reg_we_q       <= writes_reg(instr[15:12]);
                        // Flags cannot change while idle, so evaluating here matches EXEC.
                        branch_taken_q <= ((instr[15:12] == OP_B) || (instr[15:12] == OP_BR))
                                          && cond_met(instr[11:9], flags_q);
                    end
                end
                EXEC: begin
                    flags_q        <= flags_d;
                    dec_valid_q    <= 1'b0;
                    reg_we_q       <= 1'b0;
                    branch_taken_q <= 1'b0;
                    case (instr_q[15:12])
                        OP_LW, OP_SW: begin
                            state_q   <= MEM;
                            mem_req_q <= 1'b1;
                            mem_we_q  <= (instr_q[15:12] == OP_SW);
                        end
                        OP_HLT: begin
                            state_q  <= HALT;
                            halted_q <= 1'b1;
                        end
                        default: begin
                            state_q       <= IDLE;
                            instr_ready_q <= 1'b1;
                        end
                    endcase
                end
                MEM: begin
                    if (mem_ack) begin
                        state_q       <= IDLE;
                        mem_req_q     <= 1'b0;
                        mem_we_q      <= 1'b0;
                        instr_ready_q <= 1'b1;
                    end
                end
                HALT: begin
                    halted_q      <= 1'b1;
                    instr_ready_q <= 1'b0;
                end
                default: begin
                    state_q        <= IDLE;
                    instr_ready_q  <= 1'b1;
                    dec_valid_q    <= 1'b0;
                    reg_we_q       <= 1'b0;
                    mem_req_q      <= 1'b0;
                    mem_we_q       <= 1'b0;
                    branch_taken_q <= 1'b0;
                    halted_q       <= 1'b0;
                end
            endcase
        end
    end

    // LW write-back must coincide with the ack cycle, so it bypasses the output register.
    assign lw_done_s = (state_q == MEM) && mem_ack && (instr_q[15:12] == OP_LW);

    assign instr_ready  = instr_ready_q;
    assign alu_op       = instr_q[15:12];
    assign rd_sel       = instr_q[11:8];
    assign rs_sel       = rs_sel_s;
    assign rt_sel       = instr_q[3:0];
    assign imm          = imm_s;
    assign use_imm      = use_imm_s;
    assign dec_valid    = dec_valid_q;
    assign reg_we       = reg_we_q | lw_done_s;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign flags        = flags_q;
    assign branch_taken = branch_taken_q;
    assign halted       = halted_q;

endmodule
